// File: rtl/bp_trace_encoder_if.sv
// Commit-side and trace-side buses of the branch trace encoder, plus their packet types.
// master = producer/consumer environment, slave = the encoder itself.
package bp_trace_encoder_pkg;
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] npc;
        logic [31:0] inst;
        logic        priv_mode;
    } bp_commit_pkt_s;

    typedef struct packed {
        logic [5:0]  mcode;
        logic [15:0] timestamp;
        logic [63:0] addr;
    } nexus_trace_pkt_s;

    localparam logic [5:0] NEXUS_MCODE_DIRECT_BRANCH = 6'd3;
    localparam logic [5:0] NEXUS_MCODE_COMPRESSED    = 6'd4;
endpackage

interface bp_trace_encoder_if;
    import bp_trace_encoder_pkg::*;

    bp_commit_pkt_s   commit_pkt_i;
    logic             commit_valid_i;
    nexus_trace_pkt_s trace_pkt_o;
    logic             trace_valid_o;
    logic             trace_ready_i;

    modport master (
        output commit_pkt_i, commit_valid_i, trace_ready_i,
        input  trace_pkt_o, trace_valid_o
    );

    modport slave (
        input  commit_pkt_i, commit_valid_i, trace_ready_i,
        output trace_pkt_o, trace_valid_o
    );
endinterface

// File: rtl/bp_trace_encoder.sv
// Turns retired-instruction commits into full/compressed Nexus branch messages.
// One cycle commit-to-valid; a full FIFO drops the message and forces the next one to be full.
module bp_trace_encoder
    import bp_trace_encoder_pkg::*;
#(
    parameter int fifo_depth_p   = 4,
    parameter int offset_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_trace_encoder_if.slave      trc
);
    localparam int ptr_w = $clog2(fifo_depth_p);

    nexus_trace_pkt_s        mem_q [fifo_depth_p];
    logic [ptr_w-1:0]        rd_ptr_q;
    logic [ptr_w-1:0]        wr_ptr_q;
    logic [ptr_w:0]          count_q;

    logic [15:0]             delta_q;
    logic [63:0]             last_pc_q;
    logic                    last_priv_q;
    logic                    first_q;
    logic                    resync_q;

    logic [63:0]             offset;
    logic [64-offset_width_p:0] offset_hi;
    logic                    in_range;
    logic                    need_full;
    nexus_trace_pkt_s        msg;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    unused_fields;

    assign unused_fields = ^{trc.commit_pkt_i.npc, trc.commit_pkt_i.inst};

    assign offset    = trc.commit_pkt_i.pc - last_pc_q;
    // Offset fits when every bit above the signed field matches its sign bit.
    assign offset_hi = offset[63:offset_width_p-1];
    assign in_range  = (offset_hi == '0) || (&offset_hi);
    assign need_full = first_q || resync_q || !in_range ||
                       (trc.commit_pkt_i.priv_mode != last_priv_q);

    always_comb begin
        msg           = '0;
        msg.timestamp = delta_q;
        if (need_full) begin
            msg.mcode = NEXUS_MCODE_DIRECT_BRANCH;
            msg.addr  = trc.commit_pkt_i.pc;
        end else begin
            msg.mcode = NEXUS_MCODE_COMPRESSED;
            msg.addr  = offset;
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (ptr_w+1)'(fifo_depth_p));
    assign pop        = !fifo_empty && trc.trace_ready_i;
    assign push       = trc.commit_valid_i && (!fifo_full || pop);

    assign trc.trace_valid_o = !fifo_empty;
    assign trc.trace_pkt_o   = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < fifo_depth_p; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            delta_q     <= '0;
            last_pc_q   <= '0;
            last_priv_q <= 1'b0;
            first_q     <= 1'b1;
            resync_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= msg;
                wr_ptr_q        <= wr_ptr_q + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (ptr_w+1)'(1);
                2'b01:   count_q <= count_q - (ptr_w+1)'(1);
                default: count_q <= count_q;
            endcase

            if (trc.commit_valid_i) begin
                delta_q     <= 16'd1;
                last_pc_q   <= trc.commit_pkt_i.pc;
                last_priv_q <= trc.commit_pkt_i.priv_mode;
                first_q     <= 1'b0;
                resync_q    <= !push;
            end else if (delta_q != 16'hFFFF) begin
                delta_q <= delta_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_bp_trace_encoder.sv
// Directed bench for bp_trace_encoder: timestamps, offset boundaries, overflow/resync, reset.
module tb_bp_trace_encoder;
    import bp_trace_encoder_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bp_trace_encoder_if tif ();

    bp_trace_encoder #(.fifo_depth_p(4), .offset_width_p(16)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .trc     (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_msg(input string tag, input logic [5:0] mc,
                              input logic [15:0] ts, input logic [63:0] addr);
        check({tag, ".vld"},   64'(tif.trace_valid_o), 64'd1);
        check({tag, ".mcode"}, 64'(tif.trace_pkt_o.mcode), 64'(mc));
        check({tag, ".ts"},    64'(tif.trace_pkt_o.timestamp), 64'(ts));
        check({tag, ".addr"},  tif.trace_pkt_o.addr, addr);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_commit(input logic [63:0] pc, input logic priv);
        @(negedge clk);
        tif.commit_valid_i         = 1'b1;
        tif.commit_pkt_i.pc        = pc;
        tif.commit_pkt_i.priv_mode = priv;
        tif.commit_pkt_i.npc       = pc + 64'd4;
        tif.commit_pkt_i.inst      = 32'h0000_0013;
        @(posedge clk);
        #1;
        tif.commit_valid_i = 1'b0;
    endtask

    task automatic commit(input string tag, input logic [63:0] pc, input logic priv,
                          input logic [5:0] mc, input logic [15:0] ts, input logic [63:0] addr);
        drive_commit(pc, priv);
        expect_msg(tag, mc, ts, addr);
    endtask

    localparam logic [5:0] DB = NEXUS_MCODE_DIRECT_BRANCH;
    localparam logic [5:0] CM = NEXUS_MCODE_COMPRESSED;

    logic [63:0] burst_addr [4];
    logic [5:0]  burst_mc   [4];
    logic [15:0] burst_ts   [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        tif.commit_valid_i = 1'b0;
        tif.commit_pkt_i   = '0;
        tif.trace_ready_i  = 1'b1;
        #1;
        check("rst.vld",  64'(tif.trace_valid_o), 64'd0);
        check("rst.pkt",  64'(tif.trace_pkt_o.mcode) | 64'(tif.trace_pkt_o.timestamp) |
                          tif.trace_pkt_o.addr, 64'd0);
        idle(2);
        @(negedge clk);
        rst = 1'b0;

        idle(2);
        commit("first",  64'h1000, 1'b0, DB, 16'd2, 64'h1000);
        idle(3);
        commit("cmp16",  64'h1010, 1'b0, CM, 16'd4, 64'd16);
        idle(5);
        commit("far",    64'hFFFF_FFFF_8000_0000, 1'b0, DB, 16'd6, 64'hFFFF_FFFF_8000_0000);

        commit("b.base",  64'h1_0000, 1'b0, DB, 16'd1, 64'h1_0000);
        commit("b.neg_min", 64'h8000, 1'b0, CM, 16'd1, 64'hFFFF_FFFF_FFFF_8000);
        commit("b.pos_over", 64'h1_0000, 1'b0, DB, 16'd1, 64'h1_0000);
        commit("b.neg_over", 64'h7FFF, 1'b0, DB, 16'd1, 64'h7FFF);
        commit("b.base2", 64'h1_0000, 1'b0, DB, 16'd1, 64'h1_0000);
        commit("b.priv",  64'h8000, 1'b1, DB, 16'd1, 64'h8000);
        commit("b.pos_max", 64'hFFFF, 1'b1, CM, 16'd1, 64'h7FFF);
        commit("b.plus1", 64'h1_0000, 1'b1, CM, 16'd1, 64'd1);
        idle(1);

        burst_addr[0] = 64'h100; burst_mc[0] = DB; burst_ts[0] = 16'd2;
        for (int i = 1; i < 4; i++) begin
            burst_addr[i] = 64'd4; burst_mc[i] = CM; burst_ts[i] = 16'd1;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tif.trace_ready_i          = 1'b0;
            tif.commit_valid_i         = 1'b1;
            tif.commit_pkt_i.pc        = 64'h100 + 64'(4 * i);
            tif.commit_pkt_i.priv_mode = 1'b1;
            @(posedge clk);
            #1;
            expect_msg($sformatf("stall%0d", i), burst_mc[0], burst_ts[0], burst_addr[0]);
        end
        @(negedge clk);
        tif.commit_valid_i = 1'b0;
        @(posedge clk);
        #1;
        expect_msg("stall.hold", burst_mc[0], burst_ts[0], burst_addr[0]);
        @(negedge clk);
        tif.trace_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_msg($sformatf("drain%0d", i), burst_mc[i], burst_ts[i], burst_addr[i]);
            @(posedge clk);
            #1;
        end
        check("drain.empty", 64'(tif.trace_valid_o), 64'd0);
        commit("resync", 64'h200, 1'b1, DB, 16'd6, 64'h200);

        @(negedge clk);
        tif.trace_ready_i = 1'b0;
        drive_commit(64'h204, 1'b1);
        check("pre_rst.vld", 64'(tif.trace_valid_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.vld",  64'(tif.trace_valid_o), 64'd0);
        check("midrst.pkt",  64'(tif.trace_pkt_o.mcode) | 64'(tif.trace_pkt_o.timestamp) |
                             tif.trace_pkt_o.addr, 64'd0);
        @(negedge clk);
        tif.commit_valid_i  = 1'b1;
        tif.commit_pkt_i.pc = 64'h300;
        idle(2);
        @(negedge clk);
        tif.commit_valid_i = 1'b0;
        tif.trace_ready_i  = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ignore.vld", 64'(tif.trace_valid_o), 64'd0);
        commit("post_rst", 64'h208, 1'b1, DB, 16'd1, 64'h208);

        idle(70000);
        commit("sat", 64'h20C, 1'b1, CM, 16'hFFFF, 64'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
